// File: rtl/pcg32_stream_gen_if.sv
// Handshake bundle for pcg32_stream_gen: seed request channel, enable gate
// and the back-pressured output word channel.
interface pcg32_stream_gen_if #(
  parameter int OUT_W = 8
) ();
  logic             enable;
  logic             seed_valid;
  logic             seed_ready;
  logic [63:0]      seed_state;
  logic [62:0]      seed_seq;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             busy;

  // Generator side
  modport master (
    input  enable, seed_valid, seed_state, seed_seq, out_ready,
    output seed_ready, out_valid, out_data, busy
  );

  // Consumer / seed-source side
  modport slave (
    output enable, seed_valid, seed_state, seed_seq, out_ready,
    input  seed_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/pcg32_stream_gen.sv
// PCG-XSH-RR random word source: 64-bit LCG state, 32-bit permuted output,
// canonical two-step seeding, runtime stream select and valid/ready output.
module pcg32_stream_gen #(
  parameter int          OUT_W        = 8,
  parameter logic [63:0] MULT         = 64'h5851F42D4C957F2D,
  parameter logic [63:0] DEFAULT_SEED = 64'd42,
  parameter logic [62:0] DEFAULT_SEQ  = 63'd54
) (
  input  logic             clk,
  input  logic             rst_n,
  pcg32_stream_gen_if.master bus
);

  typedef enum logic [1:0] {
    SEED0 = 2'd0,
    SEED1 = 2'd1,
    SEED2 = 2'd2,
    RUN   = 2'd3
  } fsm_e;

  fsm_e             fsm_r;
  logic [63:0]      state_r;
  logic [63:0]      inc_r;
  logic [63:0]      seed_reg_r;
  logic             out_valid_r;
  logic [OUT_W-1:0] out_data_r;
  logic             busy_r;
  logic             seed_ready_r;

  logic [63:0]      step_s;
  logic [31:0]      word_s;
  logic             seed_acc_s;
  logic             gen_s;
  logic             drain_s;

  function automatic logic [63:0] lcg_step(input logic [63:0] s, input logic [63:0] inc);
    return (s * MULT) + inc;
  endfunction

  // rot == 0 leaves xs untouched: the left shift by (-0)&31 = 0 just ORs xs with itself.
  function automatic logic [31:0] pcg_out32(input logic [63:0] s);
    logic [31:0] xs;
    logic [4:0]  rot;
    xs  = 32'(((s >> 18) ^ s) >> 27);
    rot = s[63:59];
    return (xs >> rot) | (xs << ((5'd0 - rot) & 5'd31));
  endfunction

  assign step_s     = lcg_step(state_r, inc_r);
  assign word_s     = pcg_out32(state_r);
  assign seed_acc_s = bus.seed_valid && seed_ready_r;
  assign gen_s      = bus.enable && (!out_valid_r || bus.out_ready);
  assign drain_s    = out_valid_r && bus.out_ready;

  // Seeding sequencer, LCG state and output word register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r        <= SEED0;
      state_r      <= 64'd0;
      inc_r        <= {DEFAULT_SEQ, 1'b1};
      seed_reg_r   <= DEFAULT_SEED;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      busy_r       <= 1'b1;
      seed_ready_r <= 1'b0;
    end else begin
      case (fsm_r)
        SEED0: begin
          state_r <= step_s;
          fsm_r   <= SEED1;
        end
        SEED1: begin
          state_r <= state_r + seed_reg_r;
          fsm_r   <= SEED2;
        end
        SEED2: begin
          state_r      <= step_s;
          fsm_r        <= RUN;
          busy_r       <= 1'b0;
          seed_ready_r <= 1'b1;
        end
        RUN: begin
          // A reseed wins over generation and discards any pending word.
          if (seed_acc_s) begin
            state_r      <= 64'd0;
            inc_r        <= {bus.seed_seq, 1'b1};
            seed_reg_r   <= bus.seed_state;
            out_valid_r  <= 1'b0;
            fsm_r        <= SEED0;
            busy_r       <= 1'b1;
            seed_ready_r <= 1'b0;
          end else if (gen_s) begin
            out_data_r  <= word_s[31 -: OUT_W];
            state_r     <= step_s;
            out_valid_r <= 1'b1;
          end else if (drain_s) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        default: begin
          fsm_r        <= SEED0;
          state_r      <= 64'd0;
          out_valid_r  <= 1'b0;
          busy_r       <= 1'b1;
          seed_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.busy       = busy_r;
  assign bus.seed_ready = seed_ready_r;

endmodule

// File: tb/tb_pcg32_stream_gen.sv
// Directed bench for pcg32_stream_gen: 32-bit and 8-bit instances share one
// stimulus stream and are checked against the reference PCG32 (seed 42, seq 54).
module tb_pcg32_stream_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        seed_valid;
  logic [63:0] seed_state;
  logic [62:0] seed_seq;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_w [6] = '{32'ha15c02b7, 32'h7b47f409, 32'hba1d3330,
                             32'h83d2f293, 32'hbfa4784b, 32'hcbed606e};

  always #5 clk = ~clk;

  pcg32_stream_gen_if #(.OUT_W(32)) bus32 ();
  pcg32_stream_gen_if #(.OUT_W(8))  bus8 ();

  assign bus32.enable     = enable;
  assign bus32.seed_valid = seed_valid;
  assign bus32.seed_state = seed_state;
  assign bus32.seed_seq   = seed_seq;
  assign bus32.out_ready  = out_ready;
  assign bus8.enable      = enable;
  assign bus8.seed_valid  = seed_valid;
  assign bus8.seed_state  = seed_state;
  assign bus8.seed_seq    = seed_seq;
  assign bus8.out_ready   = out_ready;

  pcg32_stream_gen #(.OUT_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.master));
  pcg32_stream_gen #(.OUT_W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.master));

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input int k);
    logic [31:0] w;
    w = exp_w[k];
    check_val({tag, "_v32"}, 64'(bus32.out_valid), 64'd1);
    check_val({tag, "_d32"}, 64'(bus32.out_data), 64'(w));
    check_val({tag, "_v8"},  64'(bus8.out_valid), 64'd1);
    check_val({tag, "_d8"},  64'(bus8.out_data), 64'(w[31:24]));
  endtask

  task automatic check_ctrl(input string tag, input logic vld, input logic bsy, input logic srdy);
    check_val({tag, "_valid"}, 64'(bus32.out_valid), 64'(vld));
    check_val({tag, "_busy"},  64'(bus32.busy), 64'(bsy));
    check_val({tag, "_sready"}, 64'(bus32.seed_ready), 64'(srdy));
    check_val({tag, "_valid8"}, 64'(bus8.out_valid), 64'(vld));
  endtask

  // Mid-cycle async reset pulse with an immediate check before any clock edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_ctrl(tag, 1'b0, 1'b1, 1'b0);
    check_val({tag, "_data"}, 64'(bus32.out_data), 64'd0);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b1;
    out_ready  = 1'b1;
    seed_valid = 1'b0;
    seed_state = 64'd0;
    seed_seq   = 63'd0;

    #12;
    check_ctrl("rst", 1'b0, 1'b1, 1'b0);
    check_val("rst_data32", 64'(bus32.out_data), 64'd0);
    check_val("rst_data8", 64'(bus8.out_data), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Reset release latency and the first six reference words.
    tick(); check_ctrl("e1", 1'b0, 1'b1, 1'b0);
    tick(); check_ctrl("e2", 1'b0, 1'b1, 1'b0);
    tick(); check_ctrl("e3", 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick(); check_word($sformatf("run%0d", k), k);
    end

    // Back-pressure: hold word 1 for five cycles.
    async_reset("rst_run");
    tick(); tick(); tick();
    check_ctrl("b_e3", 1'b0, 1'b0, 1'b1);
    tick(); check_word("b_w0", 0);
    tick(); check_word("b_w1", 1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(); check_word($sformatf("stall%0d", k), 1);
    end
    out_ready = 1'b1;
    tick(); check_word("b_w2", 2);
    tick(); check_word("b_w3", 3);

    // Enable gate: pending word drains, nothing new for ten cycles.
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val($sformatf("dis%0d_valid", k), 64'(bus32.out_valid), 64'd0);
      check_val($sformatf("dis%0d_hold", k), 64'(bus32.out_data), 64'(exp_w[3]));
    end
    enable = 1'b1;
    tick(); check_word("en_w4", 4);
    tick(); check_word("en_w5", 5);

    // Reseed while stalled; further seed requests during seeding are ignored.
    out_ready = 1'b0;
    tick(); check_word("pre_seed", 5);
    seed_valid = 1'b1;
    seed_state = 64'd42;
    seed_seq   = 63'd54;
    tick(); check_ctrl("sa0", 1'b0, 1'b1, 1'b0);
    seed_state = 64'd7;
    seed_seq   = 63'd3;
    tick(); check_ctrl("sa1", 1'b0, 1'b1, 1'b0);
    tick(); check_ctrl("sa2", 1'b0, 1'b1, 1'b0);
    tick(); check_ctrl("sa3", 1'b0, 1'b0, 1'b1);
    seed_valid = 1'b0;
    out_ready  = 1'b1;
    tick(); check_word("rs_w0", 0);
    tick(); check_word("rs_w1", 1);

    // Async reset during a stall, then during SEED1.
    out_ready = 1'b0;
    tick(); check_word("pre_rst", 1);
    async_reset("rst_stall");
    out_ready = 1'b1;
    tick();
    async_reset("rst_seed1");
    tick(); tick(); tick();
    check_ctrl("r_e3", 1'b0, 1'b0, 1'b1);
    tick(); check_word("r_w0", 0);
    tick(); check_word("r_w1", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
